sram_wb_arbiter: RTL

Two-master Wishbone (pipelined) arbiter placed directly upstream of the 16-bit asynchronous-SRAM controller. It merges the CPU data port (master A) and the debug-bus port (master B) onto the controller's single slave port. Bus ownership is registered, and in-flight transactions are tracked so that acknowledgements reach only the master that issued the request. A new owner is granted only after all of the previous owner's responses have drained.

---
 rtl/sram_wb_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sram_wb_arbiter.sv
// Two-master pipelined Wishbone arbiter in front of the async-SRAM controller.
// Ownership is registered; a new owner is only granted once every response
// owed to the previous owner has drained, so acks never reach the wrong master.
module sram_wb_arbiter #(
    parameter int unsigned AW    = 16,
    parameter int unsigned LGOUT = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    // master A (CPU data port)
    input  logic          i_a_cyc,
    input  logic          i_a_stb,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [31:0]   i_a_data,
    input  logic [3:0]    i_a_sel,
    output logic          o_a_ack,
    output logic          o_a_stall,
    output logic          o_a_err,
    output logic [31:0]   o_a_data,
    // master B (debug bus)
    input  logic          i_b_cyc,
    input  logic          i_b_stb,
    input  logic          i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [31:0]   i_b_data,
    input  logic [3:0]    i_b_sel,
    output logic          o_b_ack,
    output logic          o_b_stall,
    output logic          o_b_err,
    output logic [31:0]   o_b_data,
    // slave port to the SRAM controller
    output logic          o_cyc,
    output logic          o_stb,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic [31:0]   o_data,
    output logic [3:0]    o_sel,
    input  logic          i_ack,
    input  logic          i_stall,
    input  logic          i_err,
    input  logic [31:0]   i_data
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, DRAIN} state_t;
    typedef enum logic {LAST_A, LAST_B} owner_t;

    state_t            state_q, state_d;
    owner_t            last_q, last_d;
    logic [LGOUT-1:0]  count_q, count_d;
    logic              full;
    logic              accept;

    assign full   = (count_q == '1);
    assign accept = o_stb && !i_stall;

    // Outstanding-request counter; saturates at zero so stray acks cannot wrap it.
    always_comb begin
        count_d = count_q;
        if (i_err) begin
            count_d = '0;
        end else if (accept && !i_ack) begin
            count_d = count_q + LGOUT'(1);
        end else if (i_ack && !accept && count_q != '0) begin
            count_d = count_q - LGOUT'(1);
        end
    end

    // Ownership next-state; decisions use the post-update count so a final ack
    // in this cycle already counts as drained.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (i_a_cyc && i_b_cyc) begin
                    state_d = (last_q == LAST_B) ? OWN_A : OWN_B;
                end else if (i_a_cyc) begin
                    state_d = OWN_A;
                end else if (i_b_cyc) begin
                    state_d = OWN_B;
                end
            end
            OWN_A: begin
                if (!i_a_cyc) begin
                    if (count_d != '0)  state_d = DRAIN;
                    else if (i_b_cyc)   state_d = OWN_B;
                    else                state_d = IDLE;
                end
            end
            OWN_B: begin
                if (!i_b_cyc) begin
                    if (count_d != '0)  state_d = DRAIN;
                    else if (i_a_cyc)   state_d = OWN_A;
                    else                state_d = IDLE;
                end
            end
            DRAIN: begin
                if (i_err || count_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == OWN_A) last_d = LAST_A;
        if (state_d == OWN_B) last_d = LAST_B;
        if (i_reset) begin
            state_d = IDLE;
            last_d  = LAST_B;
        end
    end

    // State, last-owner and counter registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            last_q  <= LAST_B;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    // Request-path mux and per-master stall, combinational from the owner.
    always_comb begin
        o_cyc     = 1'b0;
        o_stb     = 1'b0;
        o_we      = i_a_we;
        o_addr    = i_a_addr;
        o_data    = i_a_data;
        o_sel     = i_a_sel;
        o_a_stall = 1'b1;
        o_b_stall = 1'b1;
        case (state_q)
            OWN_A: begin
                o_cyc     = i_a_cyc;
                o_stb     = i_a_stb && !full;
                o_a_stall = i_stall || full;
            end
            OWN_B: begin
                o_cyc     = i_b_cyc;
                o_stb     = i_b_stb && !full;
                o_we      = i_b_we;
                o_addr    = i_b_addr;
                o_data    = i_b_data;
                o_sel     = i_b_sel;
                o_b_stall = i_stall || full;
            end
            DRAIN: o_cyc = 1'b1;
            default: ;
        endcase
    end

    assign o_a_ack  = i_ack && (state_q == OWN_A) && i_a_cyc;
    assign o_b_ack  = i_ack && (state_q == OWN_B) && i_b_cyc;
    assign o_a_err  = i_err && (state_q == OWN_A) && i_a_cyc;
    assign o_b_err  = i_err && (state_q == OWN_B) && i_b_cyc;
    assign o_a_data = i_data;
    assign o_b_data = i_data;

endmodule
